// File: rtl/mms_pkg.sv
// Shared constants, state encoding and pad helper for the 8-number max/min selector path.
package mms_pkg;

  localparam int NUM   = 8;
  localparam int WIDTH = 8;

  // Neutral fill values: padding never wins a max (0x00) or a min (0xFF) comparison.
  localparam logic [WIDTH-1:0] PAD_MAX = 8'h00;
  localparam logic [WIDTH-1:0] PAD_MIN = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] pad_value(input logic sel);
    return sel ? PAD_MIN : PAD_MAX;
  endfunction

endpackage

// File: rtl/mms_slot_bank.sv
// NUM x WIDTH slot register file: one indexed sample write per cycle, with optional
// pad-fill of every slot above the written index on the same edge.
module mms_slot_bank #(
  parameter int NUM   = mms_pkg::NUM,
  parameter int WIDTH = mms_pkg::WIDTH,
  parameter int IDX_W = $clog2(NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pad_en,
  input  logic [WIDTH-1:0]           pad_data,
  output logic [NUM-1:0][WIDTH-1:0]  slots
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_slot
      logic [WIDTH-1:0] slot_reg;

      // The sample write takes priority; padding only touches slots past the closing sample.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg <= '0;
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          slot_reg <= wr_data;
        end else if (pad_en && (IDX_W'(gi) > wr_idx)) begin
          slot_reg <= pad_data;
        end
      end

      assign slots[gi] = slot_reg;
    end
  endgenerate

endmodule

// File: rtl/mms_8num_loader.sv
// Serial-to-parallel frame loader feeding the 8-number max/min selector.
// Optional early frame close on in_last is enabled by defining MMS_LOADER_PARTIAL_EN.
module mms_8num_loader #(
  parameter int NUM   = mms_pkg::NUM,
  parameter int WIDTH = mms_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             select,
  output logic [WIDTH-1:0] number0,
  output logic [WIDTH-1:0] number1,
  output logic [WIDTH-1:0] number2,
  output logic [WIDTH-1:0] number3,
  output logic [WIDTH-1:0] number4,
  output logic [WIDTH-1:0] number5,
  output logic [WIDTH-1:0] number6,
  output logic [WIDTH-1:0] number7
);

  import mms_pkg::*;

  localparam int IDX_W = $clog2(NUM);

  state_t                    state_reg;
  state_t                    state_next;
  logic [IDX_W-1:0]          cnt_reg;
  logic                      sel_reg;
  logic                      xfer;
  logic                      early_last;
  logic                      close_frame;
  logic [IDX_W-1:0]          wr_idx;
  logic                      frame_sel;
  logic                      pad_en;
  logic [WIDTH-1:0]          pad_data;
  logic [NUM-1:0][WIDTH-1:0] slots;

  assign xfer = in_valid && in_ready;

`ifdef MMS_LOADER_PARTIAL_EN
  assign early_last = in_last;
`else
  logic unused_last;
  assign unused_last = in_last;
  assign early_last  = 1'b0;
`endif

  assign close_frame = (wr_idx == IDX_W'(NUM - 1)) || early_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (xfer) state_next = close_frame ? PRESENT : LOAD;
      LOAD:    if (xfer && close_frame) state_next = PRESENT;
      PRESENT: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; the first sample uses the live in_select since sel_reg is not yet loaded.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    wr_idx    = cnt_reg;
    frame_sel = sel_reg;
    case (state_reg)
      IDLE: begin
        wr_idx    = '0;
        frame_sel = in_select;
      end
      PRESENT: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      sel_reg <= 1'b0;
    end else if (xfer) begin
      cnt_reg <= wr_idx + IDX_W'(1);
      if (state_reg == IDLE) begin
        sel_reg <= in_select;
      end
    end else if (out_valid && out_ready) begin
      cnt_reg <= '0;
    end
  end

  assign pad_en   = xfer && early_last;
  assign pad_data = WIDTH'(pad_value(frame_sel));

  mms_slot_bank #(
    .NUM   (NUM),
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_slot_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (xfer),
    .wr_idx   (wr_idx),
    .wr_data  (in_data),
    .pad_en   (pad_en),
    .pad_data (pad_data),
    .slots    (slots)
  );

  assign select  = sel_reg;
  assign number0 = slots[0];
  assign number1 = slots[1];
  assign number2 = slots[2];
  assign number3 = slots[3];
  assign number4 = slots[4];
  assign number5 = slots[5];
  assign number6 = slots[6];
  assign number7 = slots[7];

endmodule
